// File: rtl/ibex_fetch_pkg.sv
// rtl/ibex_fetch_pkg.sv - shared constants, types and helpers for the fetch request path
package ibex_fetch_pkg;

   localparam int unsigned FETCH_WORD_BYTES = 4;
   localparam int unsigned MAX_NUM_REQS     = 4;
   localparam int unsigned CNT_W            = 4;

   typedef struct packed {
      logic valid;
      logic discard;
   } fetch_track_t;

   function automatic logic [CNT_W-1:0] popcount(input logic [7:0] v);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/ibex_fetch_req_ctrl_if.sv
// rtl/ibex_fetch_req_ctrl_if.sv - instruction bus request/grant/response interface
interface ibex_fetch_req_ctrl_if;

   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        instr_err_i;

   modport master (
      output instr_req_o,
      output instr_addr_o,
      input  instr_gnt_i,
      input  instr_rvalid_i,
      input  instr_rdata_i,
      input  instr_err_i
   );

   modport slave (
      input  instr_req_o,
      input  instr_addr_o,
      output instr_gnt_i,
      output instr_rvalid_i,
      output instr_rdata_i,
      output instr_err_i
   );

endinterface

// File: rtl/ibex_fetch_track.sv
// rtl/ibex_fetch_track.sv - in-order outstanding-request tracker with per-entry discard flags
module ibex_fetch_track
   import ibex_fetch_pkg::*;
#(
   parameter int unsigned NUM_REQS = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                push_i,
   input  logic                push_discard_i,
   input  logic                pop_i,
   input  logic                mark_all_discard_i,
   output logic [NUM_REQS-1:0] outstanding_o,
   output logic [CNT_W-1:0]    count_o,
   output logic                oldest_discard_o
);

   fetch_track_t r_entries [NUM_REQS];
   fetch_track_t w_next    [NUM_REQS];
   logic         w_placed;

   // Order matters: existing entries are marked, the oldest retires, then the new grant lands
   // in the first free slot so a same-cycle pop and push leave the count unchanged.
   always_comb begin
      w_next   = r_entries;
      w_placed = 1'b0;
      if (mark_all_discard_i) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            w_next[i].discard = r_entries[i].discard | r_entries[i].valid;
         end
      end
      if (pop_i) begin
         for (int i = 0; i < NUM_REQS - 1; i++) begin
            w_next[i] = w_next[i+1];
         end
         w_next[NUM_REQS-1] = '0;
      end
      if (push_i) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (!w_next[i].valid && !w_placed) begin
               w_next[i].valid   = 1'b1;
               w_next[i].discard = push_discard_i;
               w_placed          = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            r_entries[i] <= '0;
         end
      end else begin
         r_entries <= w_next;
      end
   end

   always_comb begin
      outstanding_o = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         outstanding_o[i] = r_entries[i].valid;
      end
   end

   assign count_o          = popcount(8'(outstanding_o));
   assign oldest_discard_o = r_entries[0].discard;

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// rtl/ibex_fetch_req_ctrl.sv - issues instruction-bus requests and steers responses into the fetch FIFO
module ibex_fetch_req_ctrl
   import ibex_fetch_pkg::*;
#(
   parameter int unsigned NUM_REQS = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  branch_i,
   input  logic [31:0]           branch_addr_i,
   input  logic [NUM_REQS-1:0]   fifo_busy_i,
   output logic                  fifo_clear_o,
   output logic                  fifo_valid_o,
   output logic [31:0]           fifo_addr_o,
   output logic [31:0]           fifo_rdata_o,
   output logic                  fifo_err_o,
   ibex_fetch_req_ctrl_if.master instr_bus,
   output logic                  busy_o
);

   logic                r_hold;
   logic [31:0]         r_held_addr;
   logic                r_branch_pend;
   logic [31:0]         r_fetch_addr;

   logic [31:0]         w_target;
   logic [NUM_REQS-1:0] w_outstanding;
   logic [CNT_W-1:0]    w_out_cnt;
   logic [CNT_W-1:0]    w_busy_cnt;
   logic [CNT_W-1:0]    w_sum;
   logic                w_cap_ok;
   logic                w_new_req;
   logic [31:0]         w_new_addr;
   logic                w_grant;
   logic                w_push_discard;
   logic                w_oldest_discard;

   assign w_target = {branch_addr_i[31:2], 2'b00};

   assign fifo_clear_o = branch_i;
   assign fifo_addr_o  = {branch_addr_i[31:1], 1'b0};
   assign fifo_rdata_o = instr_bus.instr_rdata_i;
   assign fifo_err_o   = instr_bus.instr_err_i;
   assign fifo_valid_o = instr_bus.instr_rvalid_i & ~w_oldest_discard & ~branch_i;

   // A branch empties the FIFO, so its busy bits no longer consume capacity this cycle.
   assign w_busy_cnt = popcount(8'(fifo_busy_i));
   assign w_sum      = w_out_cnt + (branch_i ? '0 : w_busy_cnt);
   assign w_cap_ok   = w_sum < CNT_W'(NUM_REQS);

   assign w_new_req  = req_i & w_cap_ok;
   assign w_new_addr = branch_i ? w_target : r_fetch_addr;

   assign instr_bus.instr_req_o  = r_hold | w_new_req;
   assign instr_bus.instr_addr_o = r_hold ? r_held_addr : w_new_addr;

   assign w_grant        = instr_bus.instr_req_o & instr_bus.instr_gnt_i;
   assign w_push_discard = r_hold & (branch_i | r_branch_pend);

   assign busy_o = (|w_outstanding) | r_hold;

   ibex_fetch_track #(
      .NUM_REQS(NUM_REQS)
   ) u_track (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .push_i            (w_grant),
      .push_discard_i    (w_push_discard),
      .pop_i             (instr_bus.instr_rvalid_i),
      .mark_all_discard_i(branch_i),
      .outstanding_o     (w_outstanding),
      .count_o           (w_out_cnt),
      .oldest_discard_o  (w_oldest_discard)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_hold        <= 1'b0;
         r_held_addr   <= '0;
         r_branch_pend <= 1'b0;
         r_fetch_addr  <= '0;
      end else begin
         r_hold <= instr_bus.instr_req_o & ~instr_bus.instr_gnt_i;
         if (!r_hold) begin
            r_held_addr <= w_new_addr;
         end
         if (r_hold) begin
            // A branch during a held request already retargeted fetch_addr; the grant must not undo it.
            if (instr_bus.instr_gnt_i) begin
               r_branch_pend <= 1'b0;
            end else if (branch_i) begin
               r_branch_pend <= 1'b1;
            end
            if (branch_i) begin
               r_fetch_addr <= w_target;
            end else if (instr_bus.instr_gnt_i && !r_branch_pend) begin
               r_fetch_addr <= r_held_addr + 32'(FETCH_WORD_BYTES);
            end
         end else begin
            r_branch_pend <= 1'b0;
            if (w_grant) begin
               r_fetch_addr <= w_new_addr + 32'(FETCH_WORD_BYTES);
            end else if (branch_i) begin
               r_fetch_addr <= w_target;
            end
         end
      end
   end

   a_no_rvalid_when_idle: assert property (@(posedge clk_i) disable iff (rst_i)
      instr_bus.instr_rvalid_i |-> (w_out_cnt != '0));

   a_no_grant_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
      (instr_bus.instr_req_o && instr_bus.instr_gnt_i) |-> (w_out_cnt < CNT_W'(NUM_REQS)));

   a_addr_stable_until_gnt: assert property (@(posedge clk_i) disable iff (rst_i)
      (instr_bus.instr_req_o && !instr_bus.instr_gnt_i) |=>
         (instr_bus.instr_req_o && $stable(instr_bus.instr_addr_o)));

endmodule
